// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU memory-bus decoder.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } bus_state_e;

  // Width of one per-slave wait-state field in WAIT_CYCLES.
  localparam int WAIT_FIELD_W = 4;

  // Width of the slave-ready timeout counter.
  localparam int TIMER_W = 8;

  // Read data returned to the CPU on an error completion.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_addr_decode.sv
// Region decode: turns the address select field into a mapped flag and a
// one-hot slave vector. Pure combinational so the top-level memory map can
// reuse it.
module mem_bus_addr_decode
  import mem_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_WIDTH  = 4
) (
  input  logic [SEL_WIDTH-1:0]  region,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic                  mapped,
  output logic [NUM_SLAVES-1:0] onehot
);

  assign sel    = region;
  assign mapped = (int'(region) < NUM_SLAVES);

  // One-hot select; all zero for an unmapped region.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      onehot[i] = mapped && (int'(region) == i);
    end
  end

endmodule

// File: rtl/mem_bus_decoder.sv
// Memory-bus decoder and ready generator between the CPU native memory
// interface and NUM_SLAVES peripheral slaves. Each slave completes after a
// fixed number of wait cycles or on its own ready (with timeout); unmapped
// and timed-out accesses complete with a bus error.
module mem_bus_decoder
  import mem_bus_pkg::*;
#(
  parameter int                                    NUM_SLAVES  = 4,
  parameter int                                    SEL_LSB     = 12,
  parameter int                                    SEL_WIDTH   = 4,
  parameter logic [WAIT_FIELD_W*NUM_SLAVES-1:0]    WAIT_CYCLES = '0,
  parameter logic [NUM_SLAVES-1:0]                 EXT_READY   = '0,
  parameter int                                    TIMEOUT     = 255,
  parameter logic [31:0]                           ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [3:0]               mem_wstrb,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [NUM_SLAVES-1:0]    slv_cs,
  output logic [4*NUM_SLAVES-1:0]  slv_wstrb,
  input  logic [32*NUM_SLAVES-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]    slv_ready,
  output logic                     bus_err,
  output logic [31:0]              err_addr
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  bus_state_e                state;
  logic [SEL_WIDTH-1:0]      sel_q;
  logic [31:0]               addr_q;
  logic                      ext_q;
  logic [WAIT_FIELD_W-1:0]   cnt;
  logic [TIMER_W-1:0]        timer;

  logic [SEL_WIDTH-1:0]      dec_sel;
  logic                      dec_mapped;
  logic [NUM_SLAVES-1:0]     dec_onehot;

  logic [WAIT_FIELD_W-1:0]   wait_sel;
  logic                      ext_sel;
  logic                      ready_sel;
  logic [31:0]               rdata_sel;

  mem_bus_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_addr_decode (
    .region (mem_addr[SEL_LSB +: SEL_WIDTH]),
    .sel    (dec_sel),
    .mapped (dec_mapped),
    .onehot (dec_onehot)
  );

  // Per-slave attributes of the incoming request (current address decode).
  always_comb begin
    wait_sel = '0;
    ext_sel  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dec_onehot[i]) begin
        wait_sel = WAIT_CYCLES[WAIT_FIELD_W*i +: WAIT_FIELD_W];
        ext_sel  = EXT_READY[i];
      end
    end
  end

  // Ready and read data of the slave latched at accept time.
  always_comb begin
    ready_sel = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(sel_q) == i) begin
        ready_sel = slv_ready[i];
        rdata_sel = slv_rdata[32*i +: 32];
      end
    end
  end

  // Chip selects drop during ACK so a slave never sees the next cycle's
  // request as a continuation of the one just completed.
  always_comb begin
    slv_cs    = (mem_valid && (state != ACK)) ? dec_onehot : '0;
    slv_wstrb = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      slv_wstrb[4*i +: 4] = slv_cs[i] ? mem_wstrb : 4'h0;
    end
  end

  // Read data is only meaningful in the ACK cycle.
  always_comb begin
    mem_rdata = '0;
    if (state == ACK) begin
      mem_rdata = bus_err ? ERR_DATA : rdata_sel;
    end
  end

  // Access sequencer: accept, wait (counter or slave ready), acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      err_addr  <= '0;
      sel_q     <= '0;
      addr_q    <= '0;
      ext_q     <= 1'b0;
      cnt       <= '0;
      timer     <= '0;
    end else begin
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid) begin
            sel_q  <= dec_sel;
            addr_q <= mem_addr;
            ext_q  <= 1'b0;
            timer  <= '0;
            if (!dec_mapped) begin
              state     <= ACK;
              mem_ready <= 1'b1;
              bus_err   <= 1'b1;
              err_addr  <= mem_addr;
            end else if (ext_sel) begin
              ext_q <= 1'b1;
              state <= WAIT;
            end else if (wait_sel == '0) begin
              state     <= ACK;
              mem_ready <= 1'b1;
            end else begin
              cnt   <= wait_sel - 1'b1;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!mem_valid) begin
            state <= IDLE;
          end else if (ext_q) begin
            // Slave ready wins over a coincident timeout.
            if (ready_sel) begin
              state     <= ACK;
              mem_ready <= 1'b1;
            end else if (timer == TIMER_LAST) begin
              state     <= ACK;
              mem_ready <= 1'b1;
              bus_err   <= 1'b1;
              err_addr  <= addr_q;
            end else begin
              timer <= timer + 1'b1;
            end
          end else if (cnt == '0) begin
            state     <= ACK;
            mem_ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed bench for mem_bus_decoder. Instance "a" covers zero-wait RAM,
// counted wait states, slave-driven ready, timeout and unmapped accesses;
// instance "b" has a 7-wait slave 0 for the mid-access reset case.
module tb_mem_bus_decoder;

  localparam int NS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_valid;
  logic [31:0]       mem_addr;
  logic [3:0]        mem_wstrb;
  logic [NS-1:0]     slv_ready;
  logic [32*NS-1:0]  slv_rdata;

  logic              mem_ready, bus_err;
  logic [31:0]       mem_rdata, err_addr;
  logic [NS-1:0]     slv_cs;
  logic [4*NS-1:0]   slv_wstrb;

  logic              b_mem_ready, b_bus_err;
  logic [31:0]       b_mem_rdata, b_err_addr;
  logic [NS-1:0]     b_slv_cs;
  logic [4*NS-1:0]   b_slv_wstrb;

  logic [31:0]       wdata;
  logic [31:0]       ram1;
  logic [NS-1:0]     cs_log [0:31];
  logic [4*NS-1:0]   ws_log [0:31];

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int seen;

  always #20 clk = ~clk;

  mem_bus_decoder #(
    .NUM_SLAVES  (NS),
    .SEL_LSB     (12),
    .SEL_WIDTH   (4),
    .WAIT_CYCLES (16'h0300),
    .EXT_READY   (4'b1000),
    .TIMEOUT     (16),
    .ERR_DATA    (32'hDEAD_BEEF)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .slv_cs    (slv_cs),
    .slv_wstrb (slv_wstrb),
    .slv_rdata (slv_rdata),
    .slv_ready (slv_ready),
    .bus_err   (bus_err),
    .err_addr  (err_addr)
  );

  mem_bus_decoder #(
    .NUM_SLAVES  (NS),
    .SEL_LSB     (12),
    .SEL_WIDTH   (4),
    .WAIT_CYCLES (16'h0007),
    .EXT_READY   (4'b0000),
    .TIMEOUT     (255),
    .ERR_DATA    (32'hDEAD_BEEF)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_ready (b_mem_ready),
    .mem_rdata (b_mem_rdata),
    .slv_cs    (b_slv_cs),
    .slv_wstrb (b_slv_wstrb),
    .slv_rdata (slv_rdata),
    .slv_ready (4'b0000),
    .bus_err   (b_bus_err),
    .err_addr  (b_err_addr)
  );

  // Slave models: ROM echoes the address, slave 1 is a one-word RAM,
  // slaves 2 and 3 return fixed patterns.
  assign slv_rdata = {32'h3333_3333, 32'h2222_2222, ram1, 32'hA000_0000 | mem_addr};

  always @(posedge clk) begin
    if (rst) begin
      ram1 <= '0;
    end else if (slv_cs[1]) begin
      for (int b = 0; b < 4; b++) begin
        if (slv_wstrb[4+b]) ram1[8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts an access on instance a and returns the cycle in which mem_ready
  // is seen (-1 if the budget expires). Raises slv_ready[3] from cycle
  // ready_at onward. Returns at the falling edge of the completing cycle.
  task automatic run_access(input logic [31:0] addr, input logic [3:0] wstrb,
                            input int ready_at, input int budget, output int l);
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wstrb = wstrb;
    l = -1;
    for (int n = 0; n <= budget; n++) begin
      if (n == ready_at) slv_ready[3] = 1'b1;
      @(negedge clk);
      if (n < 32) begin
        cs_log[n] = slv_cs;
        ws_log[n] = slv_wstrb;
      end
      if (mem_ready) begin
        l = n;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic end_access(input string tag);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    slv_ready = '0;
    @(negedge clk);
    check_val({tag, "_ready_pulse"}, 32'(mem_ready), 32'd0);
    check_val({tag, "_cs_idle"}, 32'(slv_cs), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    slv_ready = '0;
    wdata     = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", 32'(mem_ready), 32'd0);
    check_val("rst_err", 32'(bus_err), 32'd0);
    check_val("rst_err_addr", err_addr, 32'd0);
    check_val("rst_rdata", mem_rdata, 32'd0);
    check_val("rst_cs", 32'(slv_cs), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero-wait RAM write then read-back.
    wdata = 32'h1234_5678;
    run_access(32'h0000_1004, 4'hF, -1, 8, lat);
    check_val("wr_latency", lat, 32'd1);
    check_val("wr_cs_c0", 32'(cs_log[0]), 32'h2);
    check_val("wr_wstrb_c0", 32'(ws_log[0]), 32'h00F0);
    check_val("wr_wstrb_ack", 32'(ws_log[1]), 32'h0);
    check_val("wr_err", 32'(bus_err), 32'd0);
    end_access("wr");
    wdata = '0;

    run_access(32'h0000_1004, 4'h0, -1, 8, lat);
    check_val("rd_latency", lat, 32'd1);
    check_val("rd_data", mem_rdata, 32'h1234_5678);
    check_val("rd_wstrb_c0", 32'(ws_log[0]), 32'h0);
    end_access("rd");

    // Three counted wait states.
    run_access(32'h0000_2000, 4'h0, -1, 10, lat);
    check_val("w3_latency", lat, 32'd4);
    for (int c = 0; c < 4; c++) check_val($sformatf("w3_cs_c%0d", c), 32'(cs_log[c]), 32'h4);
    check_val("w3_cs_ack", 32'(cs_log[4]), 32'h0);
    check_val("w3_data", mem_rdata, 32'h2222_2222);
    end_access("w3");

    // Slave-driven ready raised in cycle 5.
    run_access(32'h0000_3000, 4'h0, 5, 20, lat);
    check_val("ext_latency", lat, 32'd6);
    check_val("ext_err", 32'(bus_err), 32'd0);
    check_val("ext_data", mem_rdata, 32'h3333_3333);
    end_access("ext");

    // Slave ready never comes: timeout after 16 wait cycles.
    run_access(32'h0000_3000, 4'h0, -1, 24, lat);
    check_val("to_latency", lat, 32'd17);
    check_val("to_err", 32'(bus_err), 32'd1);
    check_val("to_data", mem_rdata, 32'hDEAD_BEEF);
    check_val("to_err_addr", err_addr, 32'h0000_3000);
    end_access("to");
    check_val("to_err_drop", 32'(bus_err), 32'd0);
    check_val("to_err_addr_hold", err_addr, 32'h0000_3000);

    // Unmapped region.
    run_access(32'h0000_5000, 4'h0, -1, 8, lat);
    check_val("um_latency", lat, 32'd1);
    check_val("um_cs_c0", 32'(cs_log[0]), 32'h0);
    check_val("um_cs_c1", 32'(cs_log[1]), 32'h0);
    check_val("um_err", 32'(bus_err), 32'd1);
    check_val("um_data", mem_rdata, 32'hDEAD_BEEF);
    check_val("um_err_addr", err_addr, 32'h0000_5000);
    end_access("um");

    // Abort: valid dropped during the wait states.
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_2000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_ready) seen++;
    end
    check_val("abort_no_ready", seen, 32'd0);
    run_access(32'h0000_1004, 4'h0, -1, 8, lat);
    check_val("abort_then_rd_latency", lat, 32'd1);
    end_access("abort");

    // Back-to-back ROM reads: ready pulses two cycles apart.
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_0000;
    @(negedge clk);
    check_val("b2b_c0_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    check_val("b2b_c1_ready", 32'(mem_ready), 32'd1);
    check_val("b2b_c1_data", mem_rdata, 32'hA000_0000);
    mem_addr = 32'h0000_0004;
    @(negedge clk);
    check_val("b2b_c2_ready", 32'(mem_ready), 32'd0);
    check_val("b2b_c2_cs", 32'(slv_cs), 32'h1);
    @(negedge clk);
    check_val("b2b_c3_ready", 32'(mem_ready), 32'd1);
    check_val("b2b_c3_data", mem_rdata, 32'hA000_0004);
    @(posedge clk); #1;
    mem_valid = 1'b0;

    // Reset in the middle of a 7-wait access on instance b.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rstw_b_ready_pre", 32'(b_mem_ready), 32'd0);
    check_val("rstw_b_cs_pre", 32'(b_slv_cs), 32'h1);
    rst = 1'b1;
    mem_valid = 1'b0;
    #1;
    check_val("rstw_b_ready", 32'(b_mem_ready), 32'd0);
    check_val("rstw_b_err", 32'(b_bus_err), 32'd0);
    check_val("rstw_b_err_addr", b_err_addr, 32'd0);
    check_val("rstw_b_rdata", b_mem_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (b_mem_ready || mem_ready) seen++;
    end
    check_val("rstw_no_stray_ready", seen, 32'd0);

    // Fresh W=7 access on b after reset completes in cycle 8.
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_0000;
    lat = -1;
    for (int n = 0; n <= 14; n++) begin
      @(negedge clk);
      if (b_mem_ready) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    check_val("w7_latency", lat, 32'd8);
    check_val("w7_data", b_mem_rdata, 32'hA000_0000);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_decoder.md
# mem_bus_decoder

Parametrised memory-bus decoder and ready generator between the picorv32 native memory interface and N peripheral slaves (ROM, RAM, char RAM, LED, ...). It replaces fixed 4 KiB chip-select decoding and a single-cycle ready rule with:
- a per-slave wait-state count;
- optional slave-driven ready, with a timeout;
- bus-error completion for unmapped or timed-out accesses.

It sits in the top level, between the CPU and the slave memories.

## Interface
Parameters:
- NUM_SLAVES, 4, number of decoded regions (1..16).
- SEL_LSB, 12, lowest address bit of the region select field.
- SEL_WIDTH, 4, width of the select field; regions with index ≥ NUM_SLAVES are unmapped.
- WAIT_CYCLES, 0, packed 4 bits per slave; slave i adds WAIT_CYCLES[4i+:4] wait cycles.
- EXT_READY, 0, NUM_SLAVES-bit mask; bit i set means slave i completes on slv_ready[i] instead of the counter.
- TIMEOUT, 255, maximum WAIT cycles for an EXT_READY slave (8-bit counter, 1..255).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on bus error.

Ports:
- clk, input, 1, system clock; everything is clocked on the rising edge.
- rst, input, 1, reset. Asynchronous assertion, active-high. One clock; reset is asynchronous and active-high.
- mem_valid, input, 1, CPU request.
- mem_addr, input, 32, CPU byte address.
- mem_wstrb, input, 4, CPU byte write strobes; 0 means a read.
- mem_ready, output, 1, registered completion pulse to the CPU.
- mem_rdata, output, 32, read data to the CPU.
- slv_cs, output, NUM_SLAVES, one-hot slave select.
- slv_wstrb, output, 4*NUM_SLAVES, per-slave gated write strobes.
- slv_rdata, input, 32*NUM_SLAVES, slave read data, packed with slave i at [32i+:32].
- slv_ready, input, NUM_SLAVES, slave completion; used only where EXT_READY is set.
- bus_err, output, 1, pulse coincident with an error-completing mem_ready.
- err_addr, output, 32, mem_addr of the most recent error.

## Operation
- Decode: sel = mem_addr[SEL_LSB+:SEL_WIDTH]; mapped when sel < NUM_SLAVES.
- Slave select (combinational): slv_cs[i] = mem_valid && mapped && sel==i && state!=ACK.
- Write strobes (combinational): slv_wstrb[4i+:4] = slv_cs[i] ? mem_wstrb : 0.
- Slaves must tolerate a repeated write of identical data during wait cycles.
- State machine states: IDLE, WAIT, ACK.
- IDLE, mem_valid high:
  - latch sel, mapped and mem_addr;
  - unmapped: go to ACK with err set;
  - EXT_READY[sel]: clear the timer, go to WAIT;
  - WAIT_CYCLES[sel] == 0: go to ACK;
  - otherwise load cnt = W−1 and go to WAIT.
- WAIT, counter mode: cnt==0 goes to ACK; otherwise cnt decrements.
- WAIT, ext mode:
  - slv_ready[sel] goes to ACK;
  - timer == TIMEOUT−1 goes to ACK with err;
  - otherwise the timer increments.
  - slv_ready and the timeout in the same cycle: the access completes normally, no error.
- ACK: mem_ready=1 for exactly one cycle; bus_err=err; if err, update err_addr; next state IDLE.
- mem_rdata is combinational:
  - ACK and not err: slv_rdata[latched sel];
  - ACK and err: ERR_DATA;
  - any other state: 0.
- Abort: mem_valid low in WAIT returns to IDLE with no mem_ready.
- Address or wstrb changing while mem_valid is high is illegal; the latched sel is used.

## Timing
- Reset values: state IDLE; mem_ready 0; bus_err 0; err_addr 0; cnt 0; timer 0; mem_rdata 0.
- slv_cs and slv_wstrb are combinational and therefore 0 whenever mem_valid is low.
- Latency: accept in cycle 0; mem_ready in cycle 1+W. W=0 matches a one-cycle synchronous RAM.
- Ext mode: mem_ready is the cycle after slv_ready is sampled high.
- Timeout: mem_ready with bus_err in cycle 1+TIMEOUT.
- Unmapped access: mem_ready and bus_err in cycle 1.
- Back-to-back: a request sampled in the IDLE cycle right after ACK is accepted, giving a 2-cycle minimum period.
- rst asserted mid-access: immediate return to IDLE, outputs at reset values, no stray mem_ready after release.

## Structure
- Package mem_bus_pkg holds:
  - the state enum (IDLE/WAIT/ACK);
  - the WAIT_FIELD_W=4 and TIMER_W=8 constants;
  - the default ERR_DATA constant.
- One sub-module, mem_bus_addr_decode: combinational sel/mapped/one-hot generation, reusable by the top-level memory map.

## Test plan
- RAM slave 1 with W=0; write 0x12345678 to 0x1004 with strobe 4'hF, then read it back:
  - mem_ready 1 cycle after valid on each access;
  - the read returns 0x12345678;
  - slv_wstrb[7:4]=4'hF only while slv_cs[1] is high.
- Slave 2 with WAIT_CYCLES field = 3; read 0x2000 → mem_ready in cycle 4, a single-cycle pulse; slv_cs[2] high in cycles 0–3.
- Slave 3 with EXT_READY set; read 0x3000 with slv_ready raised after 5 cycles → mem_ready the next cycle, bus_err 0.
- Slave 3 with EXT_READY set and TIMEOUT=16; slv_ready never rises → in cycle 17:
  - mem_ready=1 and bus_err=1;
  - mem_rdata=0xDEADBEEF;
  - err_addr=0x3000.
- NUM_SLAVES=4; read 0x5000 → cycle 1 gives mem_ready with bus_err; slv_cs remains 0 throughout.
- Reset and back-to-back:
  - rst pulsed during WAIT of a W=7 access → no mem_ready afterwards, state IDLE;
  - ROM reads at 0x0000 and 0x0004 issued back-to-back → mem_ready pulses 2 cycles apart.
